// File: rtl/riscv_if_fetch_ctrl.sv
// Instruction-fetch request sequencer between the IF stage and the instruction BIU.
// Issues one bus fetch per accepted next-PC and tracks up to MAX_OUT outstanding requests
// with a PC tag per request. Responses are buffered while IF stalls, and stale responses
// are killed after a flush. Misaligned next-PCs produce a single exception parcel.
module riscv_if_fetch_ctrl #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned PARCEL_SIZE = 64,
   parameter int unsigned MAX_OUT     = 2
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [XLEN-1:0]           if_nxt_pc,
   input  logic                      if_stall,
   input  logic                      if_flush,
   output logic                      if_stall_nxt_pc,
   output logic [PARCEL_SIZE-1:0]    if_parcel,
   output logic [XLEN-1:0]           if_parcel_pc,
   output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
   output logic                      if_parcel_misaligned,
   output logic                      if_parcel_page_fault,
   output logic                      mem_req,
   output logic [XLEN-1:0]           mem_adr,
   input  logic                      mem_ack,
   input  logic                      mem_rvalid,
   input  logic [PARCEL_SIZE-1:0]    mem_rdata,
   input  logic                      mem_err
);

   localparam int unsigned PW = $clog2(MAX_OUT);
   localparam int unsigned CW = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, EXC} state_t;

   state_t state, state_nxt;

   logic [CW-1:0]          outstanding, kill, kill_nxt, buf_cnt;
   logic [PW-1:0]          tag_wptr, tag_rptr, buf_wptr, buf_rptr;
   logic [XLEN-1:0]        tag_mem  [MAX_OUT];
   logic [PARCEL_SIZE-1:0] buf_data [MAX_OUT];
   logic [XLEN-1:0]        buf_pc   [MAX_OUT];
   logic                   buf_err  [MAX_OUT];

   logic pc_misaligned, has_room, accepted;
   logic resp_ok, resp_keep, bypass, buf_push, buf_pop, exc_deliver;

   assign pc_misaligned = |if_nxt_pc[1:0];
   assign has_room      = ({1'b0, outstanding} + {1'b0, buf_cnt}) < (CW+1)'(MAX_OUT);
   assign accepted      = mem_req & mem_ack;
   // a response with nothing outstanding is a protocol error and is ignored
   assign resp_ok       = mem_rvalid & (outstanding != '0);
   assign resp_keep     = resp_ok & (kill == '0) & ~if_flush;
   // an empty buffer lets a response go straight to the outputs for 1-cycle latency
   assign bypass        = resp_keep & (buf_cnt == '0) & ~if_stall;
   assign buf_push      = resp_keep & ~bypass;
   assign buf_pop       = (buf_cnt != '0) & ~if_stall & ~if_flush;
   assign exc_deliver   = (state == EXC) & ~if_stall & ~if_flush;

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // kill count: a flush outside DRAIN kills everything still in flight
   always_comb begin
      kill_nxt = kill;
      if (if_flush && state != DRAIN) kill_nxt = outstanding - CW'(resp_ok);
      else if (resp_ok && kill != '0)  kill_nxt = kill - CW'(1);
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = RUN;
         RUN: begin
            if (if_flush) begin
               if (outstanding != '0) state_nxt = DRAIN;
            end else if (pc_misaligned && outstanding == '0 && buf_cnt == '0) begin
               state_nxt = EXC;
            end
         end
         DRAIN: if (kill_nxt == '0) state_nxt = RUN;
         EXC:   if (if_flush || !if_stall) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // bus request outputs
   always_comb begin
      mem_req         = (state == RUN) & ~if_stall & ~if_flush & has_room & ~pc_misaligned;
      mem_adr         = (state == RUN) ? if_nxt_pc : '0;
      if_stall_nxt_pc = ~(mem_req & mem_ack);
   end

   // outstanding/kill counters and FIFO pointers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding <= '0;
         kill        <= '0;
         tag_wptr    <= '0;
         tag_rptr    <= '0;
         buf_wptr    <= '0;
         buf_rptr    <= '0;
         buf_cnt     <= '0;
      end else begin
         outstanding <= outstanding + CW'(accepted) - CW'(resp_ok);
         kill        <= kill_nxt;
         if (accepted) tag_wptr <= tag_wptr + PW'(1);
         if (resp_ok)  tag_rptr <= tag_rptr + PW'(1);
         if (if_flush) begin
            buf_wptr <= '0;
            buf_rptr <= '0;
            buf_cnt  <= '0;
         end else begin
            if (buf_push) buf_wptr <= buf_wptr + PW'(1);
            if (buf_pop)  buf_rptr <= buf_rptr + PW'(1);
            buf_cnt <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
         end
      end
   end

   // tag FIFO and response buffer storage
   always_ff @(posedge clk) begin
      if (accepted) tag_mem[tag_wptr] <= if_nxt_pc;
      if (buf_push) begin
         buf_data[buf_wptr] <= mem_rdata;
         buf_pc[buf_wptr]   <= tag_mem[tag_rptr];
         buf_err[buf_wptr]  <= mem_err;
      end
   end

   // parcel outputs: exception parcel, else buffer head, else bypassed response
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         if_parcel            <= '0;
         if_parcel_pc         <= '0;
         if_parcel_valid      <= '0;
         if_parcel_misaligned <= 1'b0;
         if_parcel_page_fault <= 1'b0;
      end else begin
         if_parcel_valid <= '0;
         if (exc_deliver) begin
            if_parcel            <= '0;
            if_parcel_pc         <= if_nxt_pc;
            if_parcel_valid      <= '1;
            if_parcel_misaligned <= 1'b1;
            if_parcel_page_fault <= 1'b0;
         end else if (buf_pop) begin
            if_parcel            <= buf_data[buf_rptr];
            if_parcel_pc         <= buf_pc[buf_rptr];
            if_parcel_valid      <= '1;
            if_parcel_misaligned <= |buf_pc[buf_rptr][1:0];
            if_parcel_page_fault <= buf_err[buf_rptr];
         end else if (bypass) begin
            if_parcel            <= mem_rdata;
            if_parcel_pc         <= tag_mem[tag_rptr];
            if_parcel_valid      <= '1;
            if_parcel_misaligned <= |tag_mem[tag_rptr][1:0];
            if_parcel_page_fault <= mem_err;
         end
      end
   end

   // responses must only arrive for outstanding requests
   assert property (@(posedge clk) disable iff (!rstn) !(mem_rvalid && outstanding == '0));

endmodule

// File: tb/tb_riscv_if_fetch_ctrl.sv
// Scoreboard bench for riscv_if_fetch_ctrl: a BIU model returns responses after a fixed
// latency, expected parcels are queued on request acceptance and compared on delivery.
module tb_riscv_if_fetch_ctrl;

   localparam int XLEN = 64;
   localparam int PS   = 64;
   localparam int MO   = 2;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [XLEN-1:0] if_nxt_pc;
   logic            if_stall, if_flush, if_stall_nxt_pc;
   logic [PS-1:0]   if_parcel;
   logic [XLEN-1:0] if_parcel_pc;
   logic [PS/16-1:0] if_parcel_valid;
   logic            if_parcel_misaligned, if_parcel_page_fault;
   logic            mem_req, mem_ack, mem_rvalid, mem_err;
   logic [XLEN-1:0] mem_adr;
   logic [PS-1:0]   mem_rdata;

   always #5 clk = ~clk;

   riscv_if_fetch_ctrl #(.XLEN(XLEN), .PARCEL_SIZE(PS), .MAX_OUT(MO)) dut (
      .clk(clk), .rstn(rstn),
      .if_nxt_pc(if_nxt_pc), .if_stall(if_stall), .if_flush(if_flush),
      .if_stall_nxt_pc(if_stall_nxt_pc),
      .if_parcel(if_parcel), .if_parcel_pc(if_parcel_pc), .if_parcel_valid(if_parcel_valid),
      .if_parcel_misaligned(if_parcel_misaligned), .if_parcel_page_fault(if_parcel_page_fault),
      .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   typedef struct {logic [63:0] pc; logic [63:0] data; logic err; logic mis;} exp_t;
   typedef struct {logic [63:0] pc; int due;} pend_t;

   exp_t  exp_q[$];
   pend_t pend_q[$];

   int total = 0;
   int bad   = 0;

   int          cyc = 0;
   logic [63:0] drv_pc = '0;
   logic        drv_stall = 1'b0, drv_flush = 1'b0, auto_inc = 1'b0, chk_out = 1'b0;
   int          ack_budget = 0, lat = 1, out_cnt = 0;
   logic [63:0] err_addr = '1;
   int          par_cnt = 0, last_par_cyc = 0, rv_cyc = 0, acc_cyc = 0, p0 = 0, rel = 0;
   logic        last_req = 1'b0, last_stall_nxt = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_data(input logic [63:0] a);
      return 64'h0000_0013_0000_0013 ^ {32'h0, a[31:0] ^ 32'h8000_0000};
   endfunction

   // one clock cycle: observe parcels, drive BIU and IF inputs, record acceptance
   task automatic cycle();
      exp_t  e;
      pend_t p;
      logic  acc;
      @(negedge clk);
      cyc++;
      if (if_parcel_valid != '0) begin
         par_cnt++;
         last_par_cyc = cyc;
         check("vld_ones", 64'(if_parcel_valid), 64'hF);
         check("parcel_expected", 64'(1), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("par_pc", if_parcel_pc, e.pc);
            check("par_data", if_parcel, e.data);
            check("par_pf", 64'(if_parcel_page_fault), 64'(e.err));
            check("par_mis", 64'(if_parcel_misaligned), 64'(e.mis));
         end
      end
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      mem_err    = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
         p = pend_q.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = model_data(p.pc);
         mem_err    = (p.pc == err_addr);
         rv_cyc     = cyc;
         out_cnt--;
      end
      if_nxt_pc = drv_pc;
      if_stall  = drv_stall;
      if_flush  = drv_flush;
      mem_ack   = (ack_budget > 0);
      #1;
      last_req       = mem_req;
      last_stall_nxt = if_stall_nxt_pc;
      if (mem_req) check("mem_adr", mem_adr, drv_pc);
      acc = mem_req & mem_ack;
      if (drv_flush) exp_q.delete();
      if (acc) begin
         ack_budget--;
         acc_cyc = cyc;
         out_cnt++;
         pend_q.push_back('{pc: drv_pc, due: cyc + lat});
         exp_q.push_back('{pc: drv_pc, data: model_data(drv_pc), err: (drv_pc == err_addr), mis: 1'b0});
         if (auto_inc) drv_pc = drv_pc + 64'd8;
      end
      if (chk_out) check("outst_le_max", 64'(out_cnt <= MO), 64'd1);
   endtask

   // run until every request has returned and every parcel has been seen
   task automatic settle();
      ack_budget = 0;
      drv_stall  = 1'b0;
      drv_flush  = 1'b0;
      auto_inc   = 1'b0;
      chk_out    = 1'b0;
      for (int i = 0; i < 40 && (pend_q.size() != 0 || exp_q.size() != 0); i++) cycle();
      cycle();
      cycle();
      check("settle_empty", 64'(pend_q.size() + exp_q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      if_nxt_pc = 64'h8000_0000; if_stall = 1'b0; if_flush = 1'b0;
      mem_ack = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_stall_nxt", 64'(if_stall_nxt_pc), 64'd1);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_adr", mem_adr, 64'd0);
      check("rst_parcel", if_parcel, 64'd0);
      check("rst_parcel_pc", if_parcel_pc, 64'd0);
      check("rst_valid", 64'(if_parcel_valid), 64'd0);
      check("rst_mis", 64'(if_parcel_misaligned), 64'd0);
      check("rst_pf", 64'(if_parcel_page_fault), 64'd0);
      @(posedge clk);
      #1 rstn = 1'b1;

      // single fetch
      drv_pc = 64'h8000_0000; ack_budget = 1; lat = 1;
      cycle();
      check("t1_idle_req", 64'(last_req), 64'd0);
      check("t1_idle_stall", 64'(last_stall_nxt), 64'd1);
      cycle();
      check("t1_req", 64'(last_req), 64'd1);
      check("t1_ack_stall", 64'(last_stall_nxt), 64'd0);
      cycle();
      check("t1_post_stall", 64'(last_stall_nxt), 64'd1);
      cycle();
      check("t1_latency", 64'(last_par_cyc), 64'(rv_cyc + 1));
      check("t1_pc", if_parcel_pc, 64'h8000_0000);
      settle();

      // streaming
      drv_pc = 64'h8000_0000; ack_budget = 12; lat = 2; auto_inc = 1'b1; chk_out = 1'b1;
      p0 = par_cnt;
      repeat (30) cycle();
      settle();
      check("t2_count", 64'(par_cnt - p0), 64'd12);

      // flush with two outstanding
      drv_pc = 64'h8000_0020; lat = 4; ack_budget = 2; auto_inc = 1'b1;
      cycle();
      cycle();
      check("t3_two_out", 64'(out_cnt), 64'd2);
      auto_inc = 1'b0; drv_flush = 1'b1; drv_pc = 64'h8000_0100; ack_budget = 1;
      p0 = par_cnt;
      cycle();
      check("t3_flush_noreq", 64'(last_req), 64'd0);
      drv_flush = 1'b0;
      cycle();
      check("t3_drain_stall", 64'(last_stall_nxt), 64'd1);
      for (int i = 0; i < 20 && ack_budget > 0; i++) cycle();
      check("t3_acc", 64'(ack_budget), 64'd0);
      check("t3_acc_after_drop", 64'(acc_cyc), 64'(rv_cyc + 1));
      check("t3_no_parcel", 64'(par_cnt - p0), 64'd0);
      settle();

      // stall while responses return
      drv_pc = 64'h8000_0040; lat = 2; ack_budget = 2; auto_inc = 1'b1;
      cycle();
      cycle();
      auto_inc = 1'b0; drv_stall = 1'b1;
      p0 = par_cnt;
      repeat (5) begin
         cycle();
         check("t4_stall_noreq", 64'(last_req), 64'd0);
      end
      check("t4_stall_nopar", 64'(par_cnt - p0), 64'd0);
      drv_stall = 1'b0;
      rel = cyc + 1;
      cycle();
      cycle();
      check("t4_first", 64'(last_par_cyc), 64'(rel + 1));
      cycle();
      check("t4_second", 64'(last_par_cyc), 64'(rel + 2));
      check("t4_two_par", 64'(par_cnt - p0), 64'd2);
      settle();

      // misaligned next-PC
      drv_pc = 64'h8000_0002; ack_budget = 1;
      p0 = par_cnt;
      exp_q.push_back('{pc: 64'h8000_0002, data: 64'd0, err: 1'b0, mis: 1'b1});
      cycle();
      check("t5_noreq_run", 64'(last_req), 64'd0);
      cycle();
      check("t5_noreq_exc", 64'(last_req), 64'd0);
      check("t5_exc_stall", 64'(last_stall_nxt), 64'd1);
      drv_pc = 64'h8000_0080; ack_budget = 0;
      cycle();
      check("t5_one_par", 64'(par_cnt - p0), 64'd1);
      check("t5_mis", 64'(if_parcel_misaligned), 64'd1);
      settle();

      // bus error
      err_addr = 64'h8000_0010; drv_pc = 64'h8000_0010; lat = 1; ack_budget = 2; auto_inc = 1'b1;
      p0 = par_cnt;
      repeat (6) cycle();
      settle();
      check("t6_count", 64'(par_cnt - p0), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
